// File: rtl/alu_result_stage.sv
// ALU result output stage: tags each result with zero/negative/parity flags and
// buffers up to two results in a skid FIFO, counting delivered results.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [OPW-1:0]   in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [OPW-1:0]   out_op,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_parity,
    output logic [CNTW-1:0]  res_count
);

    typedef struct packed {
        logic [OPW-1:0]   op;
        logic             parity;
        logic             neg;
        logic             zero;
        logic [WIDTH-1:0] result;
    } entry_t;

    entry_t          ent_q [2];
    entry_t          ent_d [2];
    entry_t          out_q;
    entry_t          out_d;
    logic            head_q, head_d;
    logic            tail_q, tail_d;
    logic [1:0]      occ_q, occ_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            push, pop;

    // Handshake: a beat transfers on a side when valid and ready are both high
    // at the rising edge; ready depends only on registered occupancy.
    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        ent_d  = ent_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        if (push) begin
            ent_d[tail_q].op     = in_op;
            ent_d[tail_q].parity = ^in_result;
            ent_d[tail_q].neg    = in_result[WIDTH-1];
            ent_d[tail_q].zero   = (in_result == '0);
            ent_d[tail_q].result = in_result;
            tail_d = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        // Output register tracks the next head; when the buffer drains it keeps
        // the last delivered entry instead of exposing a stale slot.
        if (occ_d != 2'd0) out_d = ent_d[head_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            out_q    <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            occ_q    <= 2'd0;
            cnt_q    <= '0;
        end else begin
            ent_q[0] <= ent_d[0];
            ent_q[1] <= ent_d[1];
            out_q    <= out_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_result = out_q.result;
    assign out_op     = out_q.op;
    assign out_zero   = out_q.zero;
    assign out_neg    = out_q.neg;
    assign out_parity = out_q.parity;
    assign res_count  = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed steps plus random traffic against a
// queue-based reference model; a narrow-counter instance covers saturation.
module tb_alu_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_result;
    logic [2:0]  in_op;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_op;
    logic        out_zero, out_neg, out_parity;
    logic [15:0] res_count;

    logic        s_in_valid, s_in_ready;
    logic [31:0] s_in_result;
    logic [2:0]  s_in_op;
    logic        s_out_valid, s_out_ready;
    logic [31:0] s_out_result;
    logic [2:0]  s_out_op;
    logic        s_out_zero, s_out_neg, s_out_parity;
    logic [3:0]  s_res_count;

    int n_assert = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    int exp_cnt  = 0;
    logic [34:0] exp_q[$];

    alu_result_stage u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_op(out_op),
        .out_zero(out_zero), .out_neg(out_neg), .out_parity(out_parity),
        .res_count(res_count)
    );

    alu_result_stage #(.WIDTH(32), .OPW(3), .CNTW(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_result(s_in_result), .in_op(s_in_op),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_result(s_out_result), .out_op(s_out_op),
        .out_zero(s_out_zero), .out_neg(s_out_neg), .out_parity(s_out_parity),
        .res_count(s_res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_parity(input logic [31:0] r);
        return logic'($countones(r) % 2);
    endfunction

    // One handshake cycle on the main instance, checked at the falling edge.
    task automatic beat(input logic v, input logic [31:0] r, input logic [2:0] op, input logic ordy);
        logic [34:0] head;
        bit do_push, do_pop;
        in_valid  = v;
        in_result = r;
        in_op     = op;
        out_ready = ordy;
        @(negedge clk);
        check("in_ready", in_ready, exp_q.size() < 2);
        check("out_valid", out_valid, exp_q.size() != 0);
        check("res_count", res_count, exp_cnt);
        do_push = v && (exp_q.size() < 2);
        do_pop  = ordy && (exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("out_result", out_result, head[31:0]);
            check("out_op", out_op, head[34:32]);
            check("out_zero", out_zero, head[31:0] == 32'd0);
            check("out_neg", out_neg, head[31:0] >= 32'h8000_0000);
            check("out_parity", out_parity, exp_parity(head[31:0]));
        end
        if (do_pop) begin
            void'(exp_q.pop_front());
            n_pops++;
            if (exp_cnt < 65535) exp_cnt++;
        end
        if (do_push) exp_q.push_back({op, r});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b1; in_result = 32'hDEAD_BEEF; in_op = 3'd5; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_result = '0; s_in_op = '0; s_out_ready = 1'b0;

        // Reset held three cycles with in_valid high
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_res_count", res_count, 16'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_op", out_op, 3'd0);
        check("rst_flags", {out_zero, out_neg, out_parity}, 3'b000);
        in_valid = 1'b0; in_result = 'x; in_op = 'x;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);

        // Idle cycles with unknown data must not leak into the outputs
        repeat (2) @(posedge clk);
        #1;
        check("x_out_result", out_result, 32'd0);
        check("x_flags", {out_zero, out_neg, out_parity}, 3'b000);
        check("x_out_valid", out_valid, 1'b0);

        // Single pass
        beat(1'b1, 32'hF0F0_00FF, 3'b010, 1'b1);
        check("single_neg", out_neg, 1'b1);
        check("single_par", out_parity, 1'b0);
        beat(1'b0, 32'd0, 3'd0, 1'b1);
        beat(1'b0, 32'd0, 3'd0, 1'b1);
        check("single_count", res_count, 16'd1);

        // Zero and parity flags
        beat(1'b1, 32'h0000_0000, 3'b001, 1'b0);
        check("zero_flag", out_zero, 1'b1);
        beat(1'b0, 32'd0, 3'd0, 1'b1);
        beat(1'b1, 32'h0000_0001, 3'b100, 1'b0);
        check("parity_flag", out_parity, 1'b1);
        beat(1'b0, 32'd0, 3'd0, 1'b1);
        beat(1'b0, 32'd0, 3'd0, 1'b1);

        // Backpressure: fill, offer a third, then drain
        beat(1'b1, 32'h1, 3'd1, 1'b0);
        beat(1'b1, 32'h2, 3'd2, 1'b0);
        beat(1'b1, 32'h3, 3'd3, 1'b0);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_head", out_result, 32'h1);
        beat(1'b1, 32'h3, 3'd3, 1'b1);
        beat(1'b1, 32'h3, 3'd3, 1'b1);
        for (int i = 0; i < 4; i++) beat(1'b0, 32'd0, 3'd0, 1'b1);
        check("bp_drained", exp_q.size(), 0);

        // Random traffic until 200 pops after a fresh reset
        rst_n = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        n_pops = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3000 && n_pops < 200; i++)
            beat(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)));
        check("rand_pops_done", n_pops, 200);
        beat(1'b0, 32'd0, 3'd0, 1'b0);
        check("rand_count", res_count, 16'd200);

        // Narrow counter saturates
        s_in_valid = 1'b1; s_out_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            s_in_result = $urandom; s_in_op = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        check("sat_count", s_res_count, 4'hF);
        s_in_valid = 1'b0;

        // Asynchronous reset pulse with data buffered
        beat(1'b1, 32'hAAAA_0001, 3'd6, 1'b0);
        beat(1'b1, 32'hAAAA_0002, 3'd7, 1'b0);
        check("pre_pulse_full", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("pulse_out_valid", out_valid, 1'b0);
        check("pulse_count", res_count, 16'd0);
        check("pulse_sat_count", s_res_count, 4'h0);
        check("pulse_in_ready", in_ready, 1'b1);
        exp_q.delete();
        exp_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        beat(1'b1, 32'h8000_0000, 3'd2, 1'b1);
        beat(1'b0, 32'd0, 3'd0, 1'b1);
        beat(1'b0, 32'd0, 3'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
